// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and default constants for the FIFO write arbiter
package fifo_arb_pkg;

  // Two-phase write sequencing: arbitrate, then spend one cycle presenting the write
  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_W      = 16;
  localparam int MAX_N_REQ      = 16;

  // Index width for a requester count; a single requester still needs one bit
  function automatic int req_idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rtl/fifo_wr_arbiter_rr_select.sv - combinational round-robin winner search
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = req_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the index after the last winner, wrapping, and keep the first set request
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    valid      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(last) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid                = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter for the async FIFO (optional FIFO_ARB_STALL_CNT_EN)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                        W_CLK,
  input  logic                        W_RST,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic                        FULL,
  output logic [N_REQ-1:0]            GNT,
  output logic                        W_INC,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic [CNT_W-1:0]            STALL_CNT,
  input  logic                        STALL_CLR
);

  localparam int               IDX_W    = req_idx_w(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [IDX_W-1:0]      last_q;
  logic [N_REQ-1:0]      win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_valid;
  logic                  grant;
  logic [DATA_WIDTH-1:0] win_data;

  rr_select #(
    .N_REQ(N_REQ)
  ) u_rr_select (
    .req        (REQ),
    .last       (last_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .valid      (win_valid)
  );

  // Pick the winner's word out of the packed request data bus
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant only from ARB with FULL low; WRITE always falls back to ARB so FULL is re-read after each write
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ARB: begin
        if (win_valid && !FULL) begin
          grant     = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = ARB;
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered write strobe, grant pulse, write data and round-robin pointer
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      W_INC   <= 1'b0;
      GNT     <= '0;
      WR_DATA <= '0;
      last_q  <= LAST_RST;
    end else begin
      W_INC <= grant;
      GNT   <= grant ? win_onehot : '0;
      if (grant) begin
        WR_DATA <= win_data;
        last_q  <= win_idx;
      end
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall_cycle;

  assign stall_cycle = (state == ARB) && (|REQ) && FULL;

  // Saturating count of cycles a pending request is held off by FULL; clear wins over increment
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      stall_cnt_q <= '0;
    end else if (STALL_CLR) begin
      stall_cnt_q <= '0;
    end else if (stall_cycle && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign STALL_CNT = stall_cnt_q;
`else
  logic unused_stall_clr;

  assign unused_stall_clr = STALL_CLR;
  assign STALL_CNT        = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic           W_CLK_TB = 1'b0;
  logic           r_clk    = 1'b0;
  logic           w_rst;
  logic [N-1:0]   req;
  logic [N*DW-1:0] req_data;
  logic           full_drv;
  logic           stall_clr;
  logic [N-1:0]   gnt;
  logic           w_inc;
  logic [DW-1:0]  wr_data;
  logic [15:0]    stall_cnt;
  logic [N-1:0]   unused_gnt4;
  logic           unused_winc4;
  logic [DW-1:0]  unused_wdata4;
  logic [3:0]     stall_cnt4;

  logic e2e_mode = 1'b0;
  logic e2e_rd   = 1'b0;
  logic e2e_full = 1'b0;
  logic full_in;

  int checks   = 0;
  int failures = 0;
  int winc_cnt = 0;
  logic [N-1:0] gnt_seen = '0;
  int overflow_cnt = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] rd_q[$];

  assign full_in = e2e_mode ? e2e_full : full_drv;

  always #5 W_CLK_TB = ~W_CLK_TB;
  always #12.5 r_clk = ~r_clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .CNT_W(16)) u_dut (
    .W_CLK     (W_CLK_TB),
    .W_RST     (w_rst),
    .REQ       (req),
    .REQ_DATA  (req_data),
    .FULL      (full_in),
    .GNT       (gnt),
    .W_INC     (w_inc),
    .WR_DATA   (wr_data),
    .STALL_CNT (stall_cnt),
    .STALL_CLR (stall_clr)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .CNT_W(4)) u_dut_w4 (
    .W_CLK     (W_CLK_TB),
    .W_RST     (w_rst),
    .REQ       (req),
    .REQ_DATA  (req_data),
    .FULL      (full_in),
    .GNT       (unused_gnt4),
    .W_INC     (unused_winc4),
    .WR_DATA   (unused_wdata4),
    .STALL_CNT (stall_cnt4),
    .STALL_CLR (stall_clr)
  );

  // Depth-8 FIFO write side: capture on W_INC, flag overflow, register FULL
  always @(posedge W_CLK_TB) begin
    if (e2e_mode) begin
      if (w_inc) begin
        if (fifo_q.size() >= 8) overflow_cnt++;
        fifo_q.push_back(wr_data);
      end
      e2e_full <= (fifo_q.size() >= 8);
    end
  end

  // FIFO read side on the slower clock
  always @(posedge r_clk) begin
    if (e2e_rd && fifo_q.size() > 0) rd_q.push_back(fifo_q.pop_front());
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge W_CLK_TB);
    if (w_inc) winc_cnt++;
    gnt_seen = gnt_seen | gnt;
  endtask

  initial begin
    int base;
    int sent0;
    int sent1;
    int cyc;
    logic [DW-1:0] exp_word;

    w_rst = 1'b0; req = '0; req_data = '0; full_drv = 1'b0; stall_clr = 1'b0;
    repeat (2) tick();
    check_eq("rst_w_inc", w_inc, 0);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_stall", stall_cnt, 0);
    w_rst = 1'b1;

    // fairness: all four requesting
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_eq($sformatf("fair_winc_%0d", g), w_inc, 1);
      check_eq($sformatf("fair_gnt_%0d", g), gnt, 32'(1) << (g % 4));
      check_eq($sformatf("fair_data_%0d", g), wr_data, 32'hA0 + (g % 4));
      tick();
      check_eq($sformatf("fair_gap_winc_%0d", g), w_inc, 0);
      check_eq($sformatf("fair_gap_gnt_%0d", g), gnt, 0);
      check_eq($sformatf("fair_hold_data_%0d", g), wr_data, 32'hA0 + (g % 4));
    end
    req = '0;

    // full blocking with requester 2
    base = winc_cnt;
    full_drv = 1'b1;
    req = 4'b0100;
    repeat (10) tick();
    check_eq("full_no_winc", winc_cnt - base, 0);
`ifdef FIFO_ARB_STALL_CNT_EN
    check_eq("full_stall10", stall_cnt, 10);
    check_eq("full_stall10_w4", stall_cnt4, 10);
`else
    check_eq("full_stall_off", stall_cnt, 0);
    check_eq("full_stall_off_w4", stall_cnt4, 0);
`endif
    full_drv = 1'b0;
    tick();
    check_eq("unfull_winc", w_inc, 1);
    check_eq("unfull_gnt", gnt, 4'b0100);
    check_eq("unfull_data", wr_data, 8'hA2);
    req = '0;
    tick();

    // counter clear and saturation
    full_drv = 1'b1;
    req = 4'b0100;
    repeat (3) tick();
`ifdef FIFO_ARB_STALL_CNT_EN
    check_eq("cnt_13", stall_cnt, 13);
`endif
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check_eq("cnt_clr", stall_cnt, 0);
    repeat (20) tick();
`ifdef FIFO_ARB_STALL_CNT_EN
    check_eq("cnt_20", stall_cnt, 20);
    check_eq("cnt_sat_w4", stall_cnt4, 15);
`else
    check_eq("cnt_off", stall_cnt, 0);
    check_eq("cnt_off_w4", stall_cnt4, 0);
`endif

    // withdrawal while full
    base = winc_cnt;
    gnt_seen = '0;
    req = 4'b0010;
    repeat (2) tick();
    req = '0;
    tick();
    full_drv = 1'b0;
    repeat (3) tick();
    check_eq("wd_no_winc", winc_cnt - base, 0);
    check_eq("wd_no_gnt1", gnt_seen[1], 0);

    // async reset in the middle of a write
    req = 4'b0001;
    tick();
    check_eq("mid_winc_pre", w_inc, 1);
    check_eq("mid_gnt_pre", gnt, 4'b0001);
    #2 w_rst = 1'b0;
    #1;
    check_eq("mid_rst_winc", w_inc, 0);
    check_eq("mid_rst_gnt", gnt, 0);
    check_eq("mid_rst_stall", stall_cnt, 0);
    req = 4'b0011;
    tick();
    w_rst = 1'b1;
    tick();
    check_eq("post_rst_gnt", gnt, 4'b0001);
    check_eq("post_rst_winc", w_inc, 1);
    req = '0;
    tick();

    // end-to-end against a depth-8 FIFO model
    w_rst = 1'b0;
    tick();
    w_rst = 1'b1;
    e2e_mode = 1'b1;
    sent0 = 0; sent1 = 0; cyc = 0;
    while ((sent0 < 8 || sent1 < 8) && cyc < 2000) begin
      req = {2'b00, sent1 < 8, sent0 < 8};
      req_data = {16'h0000, 8'(8'h10 + sent1), 8'(sent0)};
      tick();
      cyc++;
      if (cyc == 30) e2e_rd = 1'b1;
      if (gnt[0]) sent0++;
      if (gnt[1]) sent1++;
    end
    req = '0;
    e2e_rd = 1'b1;
    check_eq("e2e_sent", sent0 + sent1, 16);
    cyc = 0;
    while (rd_q.size() < 16 && cyc < 500) begin
      tick();
      cyc++;
    end
    check_eq("e2e_read_cnt", rd_q.size(), 16);
    for (int k = 0; k < 16; k++) begin
      exp_word = (k % 2 == 0) ? 8'(k / 2) : 8'(8'h10 + k / 2);
      if (k < rd_q.size()) check_eq($sformatf("e2e_word_%0d", k), rd_q[k], exp_word);
    end
    check_eq("e2e_overflow", overflow_cnt, 0);
`ifdef FIFO_ARB_STALL_CNT_EN
    check_eq("e2e_stall_nz", stall_cnt != 0, 1);
`else
    check_eq("e2e_stall_off", stall_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
